// File: rtl/rt_pkg.sv
// Shared ray-tracing definitions: fixed-point widths, vec3 packing, ray-word
// layout and the fixed-point multiply-shift helpers used by p_hit_calc and hit_bool.
package rt_pkg;

  localparam int unsigned Q_BITS_DEFAULT = 16;
  localparam int unsigned FX_W           = 32;
  localparam int unsigned PROD_W         = 64;
  localparam int unsigned VEC_W          = 96;
  localparam int unsigned RAY_W          = 224;
  localparam int unsigned RAY_ORIGIN_LSB = 0;
  localparam int unsigned RAY_DIR_LSB    = 96;
  localparam int unsigned RAY_T_LSB      = 192;

  // x occupies the low word, z the high word
  typedef struct packed {
    logic [FX_W-1:0] z;
    logic [FX_W-1:0] y;
    logic [FX_W-1:0] x;
  } vec3_t;

  // Arithmetic shift of a full product back to Q format (floors toward -inf)
  function automatic logic [FX_W-1:0] fx_shift(input logic signed [PROD_W-1:0] prod,
                                               input int unsigned q);
    logic signed [PROD_W-1:0] sh;
    sh = prod >>> q;
    return sh[FX_W-1:0];
  endfunction

  function automatic logic [FX_W-1:0] fx_mul_shift(input logic signed [FX_W-1:0] a,
                                                   input logic signed [FX_W-1:0] b,
                                                   input int unsigned q);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(b);
    return fx_shift(prod, q);
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// One-axis signed fixed-point multiply: product registered (S2), shift taken
// combinationally from the register so the multiplier packs into a DSP.
module fixed_mul
  import rt_pkg::*;
#(
  parameter int unsigned Q_BITS = Q_BITS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   en,
  input  logic signed [FX_W-1:0] a,
  input  logic signed [FX_W-1:0] b,
  output logic [FX_W-1:0]        res_c
);

  logic signed [PROD_W-1:0] prod_q;

  always_ff @(posedge clock) begin
    if (en) prod_q <= PROD_W'(a) * PROD_W'(b);
  end

  assign res_c = fx_shift(prod_q, Q_BITS);

endmodule

// File: rtl/p_hit_calc.sv
// Three-stage hit-point pipeline: p = origin + ((dir * t) >>> Q_BITS) per axis,
// between a FWFT input FIFO and an output FIFO with full backpressure.
module p_hit_calc
  import rt_pkg::*;
#(
  parameter int unsigned Q_BITS = Q_BITS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RAY_W-1:0] fifo_in_dout,
  input  logic             fifo_in_empty,
  output logic             fifo_in_rd_en,
  output logic [VEC_W-1:0] p_hit,
  output logic             fifo_out_wr_en,
  input  logic             fifo_out_full,
  output logic             busy,
  output logic [31:0]      point_count
);

  logic            advance;
  logic            s1_valid, s2_valid, s3_valid;
  vec3_t           ray_origin, ray_dir;
  vec3_t           s1_origin, s1_dir, s2_origin;
  logic [FX_W-1:0] s1_t;
  vec3_t           scaled;
  vec3_t           hit_next;

  assign ray_origin = vec3_t'(fifo_in_dout[RAY_ORIGIN_LSB +: VEC_W]);
  assign ray_dir    = vec3_t'(fifo_in_dout[RAY_DIR_LSB +: VEC_W]);

  // Whole pipe freezes only when the output stage is loaded and cannot drain
  assign advance        = !(s3_valid && fifo_out_full);
  assign fifo_in_rd_en  = reset && !fifo_in_empty && advance;
  assign fifo_out_wr_en = reset && s3_valid && !fifo_out_full;
  assign busy           = reset && (s1_valid || s2_valid || s3_valid);

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= fifo_in_rd_en;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Payload registers need no reset; the valid bits qualify them
  always_ff @(posedge clock) begin
    if (fifo_in_rd_en) begin
      s1_origin <= ray_origin;
      s1_dir    <= ray_dir;
      s1_t      <= fifo_in_dout[RAY_T_LSB +: FX_W];
    end
    if (advance) s2_origin <= s1_origin;
  end

  fixed_mul #(.Q_BITS(Q_BITS)) u_mul_x (
    .clock (clock), .en (advance), .a (s1_dir.x), .b (s1_t), .res_c (scaled.x)
  );
  fixed_mul #(.Q_BITS(Q_BITS)) u_mul_y (
    .clock (clock), .en (advance), .a (s1_dir.y), .b (s1_t), .res_c (scaled.y)
  );
  fixed_mul #(.Q_BITS(Q_BITS)) u_mul_z (
    .clock (clock), .en (advance), .a (s1_dir.z), .b (s1_t), .res_c (scaled.z)
  );

  always_comb begin
    hit_next   = '0;
    hit_next.x = s2_origin.x + scaled.x;
    hit_next.y = s2_origin.y + scaled.y;
    hit_next.z = s2_origin.z + scaled.z;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      p_hit <= '0;
    end else if (advance && s2_valid) begin
      p_hit <= VEC_W'(hit_next);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      point_count <= '0;
    end else if (fifo_out_wr_en) begin
      point_count <= point_count + 32'd1;
    end
  end

endmodule

// File: doc/p_hit_calc.md
P_HIT_CALC -- requirements
Module: p_hit_calc

Interface
REQ-001 Parameter Q_BITS, default 16: fractional bits of every signed 32-bit fixed-point value.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 fifo_in_dout  in  224  ray word from a first-word-fall-through input FIFO: origin [95:0], direction [191:96], t [223:192].
REQ-005 Vector packing: x in bits [31:0], y in [63:32], z in [95:64] of each 96-bit field.
REQ-006 fifo_in_empty  in  1  input FIFO empty; fifo_in_dout is valid whenever this is low.
REQ-007 fifo_in_rd_en  out  1  pops the input FIFO.
REQ-008 p_hit  out  96  hit point, packed as REQ-005; this is the p_hit input of hit_bool.
REQ-009 fifo_out_wr_en  out  1  pushes p_hit into the output FIFO.
REQ-010 fifo_out_full  in  1  output FIFO full.
REQ-011 busy  out  1  high while any pipeline stage holds valid data.
REQ-012 point_count  out  32  number of points written since reset; wraps at 2^32.

Function
REQ-013 Each axis computes p = origin + ((dir * t) >>> Q_BITS).
- The product is signed 64-bit.
- The shift is arithmetic, so it truncates toward minus infinity.
- The add wraps modulo 2^32, with no saturation.
REQ-014 The pipeline has three registered stages:
- S1: capture the input word.
- S2: form the three 64-bit products.
- S3: shift, add origin, and register p_hit.
REQ-015 The block keeps one valid bit per stage.
REQ-016 advance = NOT (s3_valid AND fifo_out_full); when advance is low, all stage registers and valid bits hold their values.
REQ-017 fifo_in_rd_en = NOT fifo_in_empty AND advance (combinational); the word is captured into S1 on the same edge.
REQ-018 fifo_out_wr_en = s3_valid AND NOT fifo_out_full (combinational).
REQ-019 Latency: a word popped in cycle N produces fifo_out_wr_en in cycle N+3, provided no stall occurs.
REQ-020 Throughput is one point per cycle when the input is non-empty and the output is not full.
REQ-021 If full asserts while s3_valid is high, the stage holds p_hit stable and writes exactly once after full deasserts. No point is dropped or duplicated.
REQ-022 Points leave in the same order they entered.
REQ-023 If the input empties mid-stream, bubbles propagate. Valid data already in the pipeline drains; it is not held back.
REQ-024 point_count increments by 1 in every cycle where fifo_out_wr_en is high.
REQ-025 busy = s1_valid OR s2_valid OR s3_valid.

Reset
REQ-026 While reset is low, on each rising edge:
- all valid bits clear;
- p_hit clears to 0;
- point_count clears to 0.
REQ-027 During reset, fifo_in_rd_en and fifo_out_wr_en are 0 and busy is 0.
REQ-028 Reset asserted mid-operation discards in-flight points. The first pop after reset releases occurs no earlier than the cycle after release.

Structure
REQ-029 Shared package rt_pkg holds:
- the Q_BITS default;
- the vec3 packed type (3 x 32);
- the ray-word field offsets;
- a fixed-point multiply-shift function shared with hit_bool.
REQ-030 The per-axis multiply-shift is one sub-module, fixed_mul, instantiated three times. It is registered internally across S2/S3 so that it maps to DSP blocks.

Verification
REQ-031 Scenario 1: origin (0,0,0), dir x=0x10000, t=0x20000 -> p_hit x=0x00020000, y=z=0, written 3 cycles after the pop.
REQ-032 Scenario 2: origin x=0x10000, dir x=0xFFFF8000, t=0x30000 -> p_hit x=0xFFFF8000.
- Check: 1.0 + (-0.5 * 3.0) = -0.5.
REQ-033 Scenario 3, truncation: dir x=0x1, t=0x8000 -> 0; dir x=0xFFFFFFFF, t=0x8000 -> 0xFFFFFFFF.
REQ-034 Scenario 4, wrap: origin x=0x7FFF0000, dir x=0x10000, t=0x20000 -> p_hit x=0x80010000.
REQ-035 Scenario 5, backpressure: stream 256 random rays and hold fifo_out_full high for 5 cycles at random points.
- Required: 256 writes, output in order, matching a software model.
- Required: point_count=256.
- Required: no fifo_in_rd_en while stalled with s3_valid high.
REQ-036 Scenario 6: pull reset low with 3 points in flight -> no further writes, busy=0, point_count=0.
- After release, a fresh stream produces correct results.
